// File: rtl/rom_download_ctrl.sv
// ROM download sequencer: captures ioctl byte writes, queues them, and commits each
// byte to the CPU or graphics SDRAM port through a toggle req/ack handshake.
module rom_download_ctrl #(
  parameter logic [7:0]  ROM_INDEX  = 8'd0,
  parameter logic [24:0] GFX_BASE   = 25'h10000,
  parameter logic [24:0] GFX_SIZE   = 25'h20000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          RESET_HOLD = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [23:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [23:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        err_overflow
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;
  localparam int ENT_W  = 1 + 25 + 8;
  localparam logic [25:0] GFX_END = {1'b0, GFX_BASE} + {1'b0, GFX_SIZE};

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic              r_wr_p0, r_wr_p1, r_dl_p0, r_dl_p1;
  logic [7:0]        r_idx_p0, r_data_p0;
  logic [24:0]       r_addr_p0;
  logic              w_wr_rise, w_accept, w_is_p1, w_is_p2, w_push_req;
  logic              w_full, w_empty, w_push, w_pop, w_drop;
  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [ENT_W-1:0]  w_head;
  logic              w_head_tag;
  logic [24:0]       w_head_addr, w_off;
  logic [7:0]        w_head_data;
  state_t            r_state, w_next;
  logic              r_cur_tag, w_ack_match;
  logic              r_p1_req, r_p2_req;
  logic [23:0]       r_p1_a, r_p2_a;
  logic [1:0]        r_p1_ds, r_p2_ds;
  logic [15:0]       r_p1_d, r_p2_d;
  logic              r_done, r_loaded, r_core_rst, r_ovf;
  logic [HOLD_W-1:0] r_hold;
  logic              w_dl_rise, w_dl_fall;

  // Stage p0: register the ioctl bus so address/data stay aligned with the strobe
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr_p0 <= 1'b0;
      r_wr_p1 <= 1'b0;
      r_dl_p0 <= 1'b0;
      r_dl_p1 <= 1'b0;
    end else begin
      r_wr_p0 <= ioctl_wr;
      r_wr_p1 <= r_wr_p0;
      r_dl_p0 <= ioctl_downl;
      r_dl_p1 <= r_dl_p0;
    end
  end

  always_ff @(posedge clk_sys) begin
    r_idx_p0  <= ioctl_index;
    r_addr_p0 <= ioctl_addr;
    r_data_p0 <= ioctl_dout;
  end

  // Stage p1: edge detect, region classification and FIFO push
  assign w_wr_rise  = r_wr_p0 & ~r_wr_p1;
  assign w_accept   = w_wr_rise & r_dl_p0 & (r_idx_p0 == ROM_INDEX);
  assign w_is_p1    = (r_addr_p0 < GFX_BASE);
  assign w_is_p2    = ~w_is_p1 & ({1'b0, r_addr_p0} < GFX_END);
  assign w_push_req = w_accept & (w_is_p1 | w_is_p2);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_dl_rise  = r_dl_p0 & ~r_dl_p1;
  assign w_dl_fall  = ~r_dl_p0 & r_dl_p1;

  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wptr] <= {w_is_p2, r_addr_p0, r_data_p0};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head      = r_mem[r_rptr];
  assign w_head_tag  = w_head[ENT_W-1];
  assign w_head_addr = w_head[32:8];
  assign w_head_data = w_head[7:0];
  assign w_off       = w_head_addr - GFX_BASE;
  assign w_ack_match = r_cur_tag ? (port2_ack == r_p2_req) : (port1_ack == r_p1_req);

  // Stage p2: scheduler, one outstanding write in FIFO order across both ports
  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty)   w_next = S_WAIT;
      S_WAIT:  if (w_ack_match) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop = 1'b0;
    if (r_state == S_IDLE && !w_empty) w_pop = 1'b1;
  end

  // Reset resynchronises req to ack so no handshake is left pending
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cur_tag <= 1'b0;
      r_p1_req  <= port1_ack;
      r_p2_req  <= port2_ack;
      r_p1_a    <= '0;
      r_p1_ds   <= '0;
      r_p1_d    <= '0;
      r_p2_a    <= '0;
      r_p2_ds   <= '0;
      r_p2_d    <= '0;
    end else if (w_pop) begin
      r_cur_tag <= w_head_tag;
      if (w_head_tag) begin
        r_p2_a   <= {w_off[24:17], w_off[14:0], w_off[16]};
        r_p2_ds  <= {w_off[15], ~w_off[15]};
        r_p2_d   <= {w_head_data, w_head_data};
        r_p2_req <= ~r_p2_req;
      end else begin
        r_p1_a   <= w_head_addr[24:1];
        r_p1_ds  <= {w_head_addr[0], ~w_head_addr[0]};
        r_p1_d   <= {w_head_data, w_head_data};
        r_p1_req <= ~r_p1_req;
      end
    end
  end

  // Completion tracking and core reset stretch
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_done     <= 1'b0;
      r_loaded   <= 1'b0;
      r_hold     <= '0;
      r_core_rst <= 1'b1;
      r_ovf      <= 1'b0;
    end else begin
      if (w_drop) r_ovf <= 1'b1;
      r_core_rst <= ~r_loaded | (r_hold != '0);
      if (w_dl_rise) begin
        r_done   <= 1'b0;
        r_loaded <= 1'b0;
        r_hold   <= '0;
      end else begin
        if (w_dl_fall) r_done <= 1'b1;
        if (r_done && !r_loaded && w_empty && r_state == S_IDLE) begin
          r_loaded <= 1'b1;
          r_hold   <= HOLD_W'(RESET_HOLD);
        end else if (r_hold != '0) begin
          r_hold <= r_hold - HOLD_W'(1);
        end
      end
    end
  end

  assign port1_req    = r_p1_req;
  assign port1_a      = r_p1_a;
  assign port1_ds     = r_p1_ds;
  assign port1_d      = r_p1_d;
  assign port2_req    = r_p2_req;
  assign port2_a      = r_p2_a;
  assign port2_ds     = r_p2_ds;
  assign port2_d      = r_p2_d;
  assign rom_loaded   = r_loaded;
  assign core_reset   = reset | r_core_rst;
  assign err_overflow = r_ovf;

endmodule

// File: doc/rom_download_ctrl.md
# rom_download_ctrl

Sequences the ROM download from the SPI data channel into the two SDRAM write ports of an arcade core. It captures ioctl byte writes into a small FIFO and routes each byte by address region: CPU region to port 1, graphics region to port 2 with 32-bit interleave remapping. It issues each write as a toggle request/acknowledge transaction, one outstanding per port, and owns the core reset and `rom_loaded` status so the core starts only after the last byte has been committed.

## Interface
Parameters:
- ROM_INDEX, 0: ioctl_index value accepted; writes with any other index are ignored.
- GFX_BASE, 25'h10000: first byte address of the graphics region; bytes below it go to port 1.
- GFX_SIZE, 25'h20000: byte size of the graphics region; bytes at or above GFX_BASE+GFX_SIZE are dropped.
- FIFO_DEPTH, 4: byte FIFO entries (power of two, ≥2).
- RESET_HOLD, 16: cycles `core_reset` stays high after `rom_loaded` rises.

Ports:
- clk_sys  in  1  system clock (48 MHz domain).
- reset  in  1  synchronous, active-high.
- ioctl_downl  in  1  download in progress.
- ioctl_index  in  8  download target index.
- ioctl_wr  in  1  byte strobe; level may last several cycles.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- port1_req  out  1  toggle request, CPU ROM writes.
- port1_ack  in  1  toggle acknowledge from SDRAM.
- port1_a  out  24  word address = addr[24:1].
- port1_ds  out  2  byte select = {addr[0], ~addr[0]}.
- port1_d  out  16  {byte, byte}.
- port2_req, port2_ack, port2_a (24), port2_ds (2), port2_d (16): same roles for graphics. With off = addr − GFX_BASE: a = {off[24:17], off[14:0], off[16]}; ds = {off[15], ~off[15]}.
- rom_loaded  out  1  sticky; set when download ends and all writes are acknowledged.
- core_reset  out  1  active-high reset for the game core.
- err_overflow  out  1  sticky; a byte was lost because the FIFO was full.

## Operation
- Edge detect: ioctl_wr is registered and a byte is accepted on its rising edge while ioctl_downl=1 and ioctl_index=ROM_INDEX. Address and data are taken from the same cycle as the detected edge.
- Classification at push time:
  - addr < GFX_BASE → tag P1.
  - GFX_BASE ≤ addr < GFX_BASE+GFX_SIZE → tag P2.
  - Otherwise the byte is discarded; it is neither pushed nor counted as an error.
- FIFO stores {tag, addr, data}.
  - Push while full with no pop in the same cycle: the byte is discarded and err_overflow is set.
  - Push and pop in the same cycle while full: the push is accepted.
- Scheduler FSM:
  - IDLE: if the FIFO is non-empty, pop the head, drive a/ds/d on the tagged port, toggle that port's req, then go to WAIT.
  - WAIT: stay until the tagged port's ack equals its req, then go to IDLE.
  - Exactly one transaction is outstanding at a time, in strict FIFO order across both ports.
  - Port outputs hold their last values between transactions.
- Completion: a sticky flag records the falling edge of ioctl_downl. rom_loaded is set once that flag is set, the FIFO is empty and the FSM is in IDLE.
- core_reset = reset | ~rom_loaded | (hold counter ≠ 0). The hold counter loads RESET_HOLD on the cycle rom_loaded rises and decrements to 0.
- A new download (rising ioctl_downl) clears rom_loaded and the completion flag, which reasserts core_reset.

## Timing
- Reset values:
  - port*_a, port*_d, port*_ds = 0.
  - rom_loaded = 0, err_overflow = 0, core_reset = 1.
  - FIFO empty, FSM in IDLE, hold counter = 0.
  - port1_req ← port1_ack and port2_req ← port2_ack, so the handshakes are resynchronised and a reset in the middle of a transaction leaves nothing pending.
- Latency: ioctl_wr high sampled at edge n → edge registered at n+1 → FIFO write at n+1 → req toggles at n+2 at the earliest (empty FIFO, FSM in IDLE).
- Back-to-back throughput: one transaction per (ack latency + 1) cycles. The cycle in which ack matches returns the FSM to IDLE; the next pop happens the following cycle.
- ioctl_downl falling while writes are queued: rom_loaded waits for the drain. It rises one cycle after the final ack match.
- core_reset falls RESET_HOLD+1 cycles after rom_loaded rises.

## Test plan
- Reset with port1_ack=1, port2_ack=0 → port1_req=1, port2_req=0; core_reset=1, rom_loaded=0.
- Write addr 25'h00003, data 8'hA5 with ack returned 5 cycles after req → port1_a=24'h1, ds=2'b10, d=16'hA5A5, one req toggle; port2 untouched.
- Write addr 25'h18001 (off=8001h) → port2_a={8'h0, 15'h0001, 1'b0}, ds=2'b10; addr 25'h30000 → no toggle on either port.
- Hold ack for 100 cycles while 6 bytes arrive 1 cycle apart → first 5 accepted (1 in flight + 4 queued), err_overflow=1, then exactly 5 toggles in order.
- Drop ioctl_downl with 3 bytes queued → rom_loaded=1 one cycle after the third ack; core_reset falls RESET_HOLD+1 cycles later.
- Assert reset while in WAIT → FSM returns to IDLE, FIFO is emptied, req=ack; a later download completes normally.
